cpu_mem_arbiter: RTL and testbench

//  N-channel arbiter/mux between CPU-internal requesters (fetch, dcache, execute, ...) and the single

---
 rtl/cpu_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// N-channel arbiter between CPU-internal requesters and a single external memory port.
// Fixed or round-robin priority, read/write, one-cycle ack, optional bus timeout with error flag.
module cpu_mem_arbiter #(
  parameter int unsigned N       = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned RR      = 1,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]    ch_req,
  input  logic [N-1:0]    ch_wr,
  input  logic [N*AW-1:0] ch_addr,
  input  logic [N*DW-1:0] ch_wdata,
  output logic [DW-1:0]   ch_rdata,
  output logic [N-1:0]    ch_ack,
  output logic [N-1:0]    ch_err,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            m_req,
  output logic            m_wr,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   data_out,
  input  logic [DW-1:0]   data_in,
  input  logic            m_ack
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    ch_ack_q, ch_ack_d;
  logic [N-1:0]    ch_err_q, ch_err_d;
  logic            busy_q, busy_d;
  logic            m_req_q, m_req_d;
  logic            m_wr_q, m_wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_out_q, data_out_d;
  logic [DW-1:0]   ch_rdata_q, ch_rdata_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  int unsigned     cand;

  // Round-robin searches upward from the channel after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (RR != 0) begin
      for (int k = 1; k <= int'(N); k++) begin
        cand = (int'(last_q) + k) % N;
        if (!win_found && ch_req[cand]) begin
          win_found = 1'b1;
          win_idx   = IW'(cand);
        end
      end
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (!win_found && ch_req[k]) begin
          win_found = 1'b1;
          win_idx   = IW'(k);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ch_ack_d   = '0;
    ch_err_d   = '0;
    busy_d     = busy_q;
    m_req_d    = m_req_q;
    m_wr_d     = m_wr_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    ch_rdata_d = ch_rdata_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          addr_d           = ch_addr[win_idx*AW +: AW];
          data_out_d       = ch_wdata[win_idx*DW +: DW];
          m_wr_d           = ch_wr[win_idx];
          m_req_d          = 1'b1;
          busy_d           = 1'b1;
          last_d           = win_idx;
          cnt_d            = '0;
          state_d          = StReq;
        end
      end
      StReq: begin
        if (m_ack) begin
          if (!m_wr_q) ch_rdata_d = data_in;
          ch_ack_d = grant_q;
          m_req_d  = 1'b0;
          m_wr_d   = 1'b0;
          cnt_d    = '0;
          state_d  = StDone;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          ch_ack_d   = grant_q;
          ch_err_d   = grant_q;
          ch_rdata_d = '0;
          m_req_d    = 1'b0;
          m_wr_d     = 1'b0;
          cnt_d      = '0;
          state_d    = StDone;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ch_ack_q   <= '0;
      ch_err_q   <= '0;
      busy_q     <= 1'b0;
      m_req_q    <= 1'b0;
      m_wr_q     <= 1'b0;
      addr_q     <= '0;
      data_out_q <= '0;
      ch_rdata_q <= '0;
      last_q     <= IW'(N - 1);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ch_ack_q   <= ch_ack_d;
      ch_err_q   <= ch_err_d;
      busy_q     <= busy_d;
      m_req_q    <= m_req_d;
      m_wr_q     <= m_wr_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      ch_rdata_q <= ch_rdata_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign ch_ack   = ch_ack_q;
  assign ch_err   = ch_err_q;
  assign busy     = busy_q;
  assign m_req    = m_req_q;
  assign m_wr     = m_wr_q;
  assign addr     = addr_q;
  assign data_out = data_out_q;
  assign ch_rdata = ch_rdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: round-robin/timeout instance (u_rr) and fixed-priority instance (u_fix),
// directed scenarios plus randomized transactions checked against a transaction-level model.
module tb_cpu_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  a_ch_req = '0, a_ch_wr = '0;
  logic [95:0] a_ch_addr = '0, a_ch_wdata = '0;
  logic [31:0] a_ch_rdata, a_addr, a_data_out;
  logic [31:0] a_data_in = '0;
  logic [2:0]  a_ch_ack, a_ch_err, a_grant;
  logic        a_busy, a_m_req, a_m_wr;
  logic        a_m_ack = 1'b0;

  logic [2:0]  b_ch_req = '0, b_ch_wr = '0;
  logic [95:0] b_ch_addr = '0, b_ch_wdata = '0;
  logic [31:0] b_ch_rdata, b_addr, b_data_out;
  logic [31:0] b_data_in = '0;
  logic [2:0]  b_ch_ack, b_ch_err, b_grant;
  logic        b_busy, b_m_req, b_m_wr;
  logic        b_m_ack = 1'b0;

  cpu_mem_arbiter #(.N(3), .AW(32), .DW(32), .RR(1), .TIMEOUT(4)) u_rr (
    .clk(clk), .reset(reset), .ch_req(a_ch_req), .ch_wr(a_ch_wr), .ch_addr(a_ch_addr),
    .ch_wdata(a_ch_wdata), .ch_rdata(a_ch_rdata), .ch_ack(a_ch_ack), .ch_err(a_ch_err),
    .grant(a_grant), .busy(a_busy), .m_req(a_m_req), .m_wr(a_m_wr), .addr(a_addr),
    .data_out(a_data_out), .data_in(a_data_in), .m_ack(a_m_ack)
  );

  cpu_mem_arbiter #(.N(3), .AW(32), .DW(32), .RR(0), .TIMEOUT(0)) u_fix (
    .clk(clk), .reset(reset), .ch_req(b_ch_req), .ch_wr(b_ch_wr), .ch_addr(b_ch_addr),
    .ch_wdata(b_ch_wdata), .ch_rdata(b_ch_rdata), .ch_ack(b_ch_ack), .ch_err(b_ch_err),
    .grant(b_grant), .busy(b_busy), .m_req(b_m_req), .m_wr(b_m_wr), .addr(b_addr),
    .data_out(b_data_out), .data_in(b_data_in), .m_ack(b_m_ack)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state for u_rr.
  int          m_last = 2;
  logic [31:0] m_rdata = '0;
  bit          pend[3];
  bit          p_wr[3];
  logic [31:0] p_addr[3], p_wdata[3];

  function automatic int rr_pick(input bit r0, input bit r1, input bit r2, input int last);
    bit r[3];
    r[0] = r0; r[1] = r1; r[2] = r2;
    for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  function automatic int fixed_pick(input logic [2:0] r);
    for (int k = 0; k < 3; k++) if (r[k]) return k;
    return -1;
  endfunction

  task automatic apply_a();
    for (int c = 0; c < 3; c++) begin
      a_ch_req[c]            = pend[c];
      a_ch_wr[c]             = p_wr[c];
      a_ch_addr[c*32 +: 32]  = p_addr[c];
      a_ch_wdata[c*32 +: 32] = p_wdata[c];
    end
  endtask

  task automatic new_req(input int c);
    pend[c]    = 1'b1;
    p_wr[c]    = 1'($urandom_range(0, 1));
    p_addr[c]  = $urandom;
    p_wdata[c] = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    m_last = 2;
    m_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_ch_req = 3'b111;
    a_m_ack = 1'b1;
    b_ch_req = 3'b111;
    b_m_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_m_req, a_grant, a_ch_ack, a_busy} !== 8'h00) begin
        errors++;
        $display("FAIL reset_rr cyc%0d: m_req=%b grant=%b ack=%b busy=%b, need all 0",
                 i, a_m_req, a_grant, a_ch_ack, a_busy);
      end
      checks++;
      if ({b_m_req, b_grant, b_ch_ack} !== 7'h00) begin
        errors++;
        $display("FAIL reset_fix cyc%0d: m_req=%b grant=%b ack=%b, need 0", i, b_m_req, b_grant,
                 b_ch_ack);
      end
    end
    checks++;
    if ({a_addr, a_data_out, a_ch_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h dout=%h rdata=%h, need 0", a_addr, a_data_out, a_ch_rdata);
    end
    a_ch_req = '0; a_m_ack = 1'b0;
    b_ch_req = '0; b_m_ack = 1'b0;
    for (int c = 0; c < 3; c++) pend[c] = 1'b0;
    apply_a();
    reset = 1'b1;
    m_last = 2;
    m_rdata = '0;
  endtask

  task automatic test_single_read();
    pend[1] = 1'b1; p_wr[1] = 1'b0; p_addr[1] = 32'h100; p_wdata[1] = 32'h0;
    apply_a();
    m_last = rr_pick(pend[0], pend[1], pend[2], m_last);
    @(posedge clk); #1;
    checks++;
    if ({a_m_req, a_m_wr, a_grant, a_addr} !== {1'b1, 1'b0, 3'b010, 32'h100}) begin
      errors++;
      $display("FAIL single_read_req: m_req=%b m_wr=%b grant=%b addr=%h, need 1 0 010 100",
               a_m_req, a_m_wr, a_grant, a_addr);
    end
    for (int k = 0; k <= 2; k++) begin
      a_m_ack = (k == 2);
      a_data_in = (k == 2) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      @(posedge clk); #1;
    end
    a_m_ack = 1'b0;
    m_rdata = 32'hDEADBEEF;
    checks++;
    if ({a_ch_ack, a_ch_err, a_ch_rdata, a_m_req} !== {3'b010, 3'b000, m_rdata, 1'b0}) begin
      errors++;
      $display("FAIL single_read_done: ack=%b err=%b rdata=%h m_req=%b, need 010 000 %h 0",
               a_ch_ack, a_ch_err, a_ch_rdata, a_m_req, m_rdata);
    end
    pend[1] = 1'b0;
    apply_a();
    @(posedge clk); #1;
    checks++;
    if ({a_ch_ack, a_grant, a_busy} !== 7'h0) begin
      errors++;
      $display("FAIL single_read_idle: ack=%b grant=%b busy=%b, need 0", a_ch_ack, a_grant, a_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    int w;
    for (int c = 0; c < 3; c++) begin
      pend[c] = 1'b1; p_wr[c] = 1'b0; p_addr[c] = 32'h1000 * (c + 1); p_wdata[c] = '0;
    end
    apply_a();
    a_m_ack = 1'b1;
    a_data_in = 32'h1234_5678;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = rr_pick(1'b1, 1'b1, 1'b1, m_last);
      m_last = w;
      exp = 3'b001 << w;
      @(posedge clk); #1;
      checks++;
      if ({a_grant, a_m_req, a_ch_ack, a_addr} !== {exp, 1'b1, 3'b000, p_addr[w]}) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b m_req=%b ack=%b addr=%h, need %b 1 000 %h",
                 i, a_grant, a_m_req, a_ch_ack, a_addr, exp, p_addr[w]);
      end
      @(posedge clk); #1;
      checks++;
      if ({a_ch_ack, a_grant, a_m_req} !== {exp, exp, 1'b0}) begin
        errors++;
        $display("FAIL rr_ack%0d: ack=%b grant=%b m_req=%b, need %b %b 0",
                 i, a_ch_ack, a_grant, a_m_req, exp, exp);
      end
      if (i == 3) begin
        for (int c = 0; c < 3; c++) pend[c] = 1'b0;
        apply_a();
        a_m_ack = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if ({a_ch_ack, a_grant} !== 6'h0) begin
        errors++;
        $display("FAIL rr_idle%0d: ack=%b grant=%b, need 0", i, a_ch_ack, a_grant);
      end
    end
    m_rdata = 32'h1234_5678;
  endtask

  task automatic test_fixed_priority();
    logic [2:0] exp;
    b_ch_req = 3'b110;
    b_m_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 3'b001 << fixed_pick(b_ch_req);
      @(posedge clk); #1;
      checks++;
      if ({b_grant, b_m_req} !== {exp, 1'b1}) begin
        errors++;
        $display("FAIL fix_grant%0d: grant=%b m_req=%b, need %b 1", i, b_grant, b_m_req, exp);
      end
      @(posedge clk); #1;
      checks++;
      if (b_ch_ack !== exp) begin
        errors++;
        $display("FAIL fix_ack%0d: ack=%b, need %b", i, b_ch_ack, exp);
      end
      if (i == 2) b_ch_req = 3'b100;
      if (i == 3) begin b_ch_req = 3'b000; b_m_ack = 1'b0; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    pend[2] = 1'b1; p_wr[2] = 1'b1; p_addr[2] = 32'h20; p_wdata[2] = 32'h55;
    apply_a();
    a_m_ack = 1'b0;
    m_last = rr_pick(pend[0], pend[1], pend[2], m_last);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_m_req, a_m_wr, a_grant, a_addr, a_data_out, a_ch_ack}
          !== {1'b1, 1'b1, 3'b100, 32'h20, 32'h55, 3'b000}) begin
        errors++;
        $display("FAIL timeout_req%0d: m_req=%b m_wr=%b grant=%b addr=%h dout=%h ack=%b",
                 k, a_m_req, a_m_wr, a_grant, a_addr, a_data_out, a_ch_ack);
      end
    end
    @(posedge clk); #1;
    m_rdata = '0;
    checks++;
    if ({a_ch_ack, a_ch_err, a_m_req, a_m_wr, a_ch_rdata} !== {3'b100, 3'b100, 2'b00, m_rdata}) begin
      errors++;
      $display("FAIL timeout_done: ack=%b err=%b m_req=%b m_wr=%b rdata=%h, need 100 100 0 0 0",
               a_ch_ack, a_ch_err, a_m_req, a_m_wr, a_ch_rdata);
    end
    pend[2] = 1'b0;
    apply_a();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_txn();
    pend[0] = 1'b1; p_wr[0] = 1'b0; p_addr[0] = 32'hC0DE_0000; p_wdata[0] = '0;
    apply_a();
    @(posedge clk); #1;
    checks++;
    if ({a_m_req, a_grant} !== 4'b1001) begin
      errors++;
      $display("FAIL midrst_req: m_req=%b grant=%b, need 1 001", a_m_req, a_grant);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_last = 2;
    m_rdata = '0;
    checks++;
    if ({a_m_req, a_grant, a_ch_ack, a_ch_err, a_busy} !== 11'h0) begin
      errors++;
      $display("FAIL midrst_drop: m_req=%b grant=%b ack=%b err=%b busy=%b, need 0",
               a_m_req, a_grant, a_ch_ack, a_ch_err, a_busy);
    end
    m_last = rr_pick(pend[0], pend[1], pend[2], m_last);
    @(posedge clk); #1;
    checks++;
    if ({a_m_req, a_grant, a_ch_ack, a_addr} !== {1'b1, 3'b001, 3'b000, 32'hC0DE_0000}) begin
      errors++;
      $display("FAIL midrst_regrant: m_req=%b grant=%b ack=%b addr=%h", a_m_req, a_grant, a_ch_ack,
               a_addr);
    end
    a_m_ack = 1'b1;
    a_data_in = 32'hFACE_0001;
    @(posedge clk); #1;
    a_m_ack = 1'b0;
    m_rdata = 32'hFACE_0001;
    checks++;
    if ({a_ch_ack, a_ch_err, a_ch_rdata} !== {3'b001, 3'b000, m_rdata}) begin
      errors++;
      $display("FAIL midrst_done: ack=%b err=%b rdata=%h, need 001 000 %h", a_ch_ack, a_ch_err,
               a_ch_rdata, m_rdata);
    end
    pend[0] = 1'b0;
    apply_a();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int w, d;
    bit any, tmo;
    logic [2:0] exp;
    logic [31:0] dv;
    for (int c = 0; c < 3; c++) pend[c] = 1'b0;
    apply_a();
    do_reset();
    for (int t = 0; t < 60; t++) begin
      for (int c = 0; c < 3; c++) if (!pend[c] && ($urandom_range(0, 1) == 1)) new_req(c);
      any = pend[0] | pend[1] | pend[2];
      if (!any) new_req(int'($urandom_range(0, 2)));
      apply_a();
      w = rr_pick(pend[0], pend[1], pend[2], m_last);
      m_last = w;
      exp = 3'b001 << w;
      @(posedge clk); #1;
      checks++;
      if ({a_grant, a_m_req, a_m_wr, a_addr, a_data_out, a_busy}
          !== {exp, 1'b1, p_wr[w], p_addr[w], p_wdata[w], 1'b1}) begin
        errors++;
        $display("FAIL rand_req t%0d: grant=%b m_req=%b m_wr=%b addr=%h dout=%h, need %b 1 %b %h %h",
                 t, a_grant, a_m_req, a_m_wr, a_addr, a_data_out, exp, p_wr[w], p_addr[w],
                 p_wdata[w]);
      end
      d = int'($urandom_range(0, 5));
      dv = '0;
      for (int k = 0; k < 4; k++) begin
        a_m_ack = (k == d);
        a_data_in = $urandom;
        dv = a_data_in;
        @(posedge clk); #1;
        if (k == d || k == 3) break;
        checks++;
        if ({a_m_req, a_ch_ack} !== 4'b1000) begin
          errors++;
          $display("FAIL rand_wait t%0d k%0d: m_req=%b ack=%b, need 1 000", t, k, a_m_req, a_ch_ack);
        end
      end
      a_m_ack = 1'b0;
      tmo = (d > 3);
      if (tmo) m_rdata = '0;
      else if (!p_wr[w]) m_rdata = dv;
      checks++;
      if ({a_ch_ack, a_ch_err, a_ch_rdata, a_m_req, a_m_wr, a_grant, a_busy}
          !== {exp, (tmo ? exp : 3'b000), m_rdata, 2'b00, exp, 1'b1}) begin
        errors++;
        $display("FAIL rand_done t%0d: ack=%b err=%b rdata=%h m_req=%b grant=%b, need %b %b %h 0 %b",
                 t, a_ch_ack, a_ch_err, a_ch_rdata, a_m_req, a_grant, exp,
                 (tmo ? exp : 3'b000), m_rdata, exp);
      end
      if ($urandom_range(0, 1) == 1) new_req(w);
      else pend[w] = 1'b0;
      apply_a();
      @(posedge clk); #1;
      checks++;
      if ({a_grant, a_ch_ack, a_m_req, a_busy} !== 8'h0) begin
        errors++;
        $display("FAIL rand_idle t%0d: grant=%b ack=%b m_req=%b busy=%b, need 0",
                 t, a_grant, a_ch_ack, a_m_req, a_busy);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < 3; c++) begin
      pend[c] = 1'b0; p_wr[c] = 1'b0; p_addr[c] = '0; p_wdata[c] = '0;
    end
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_reset_mid_txn();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
